mips_16_prog_loader: RTL
========================

MIPS_16_PROG_LOADER -- requirements
Module: mips_16_prog_loader

Interface
REQ-001 Parameter PC_WIDTH, default 8: instruction-memory address width; capacity 2^PC_WIDTH words.
REQ-002 Parameter INSTR_WIDTH, default 16: instruction word width.
REQ-003 Parameter HOLD_CYCLES, default 4: number of cycles core_rst stays high after the last word is written.
REQ-004 Port clk, input, 1: the single clock; all logic on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-low reset.
REQ-006 Port start, input, 1: single-cycle pulse that begins a (re)load.
REQ-007 Port s_valid, input, 1: upstream word valid.
REQ-008 Port s_ready, output, 1: loader accepts a word.
REQ-009 Port s_data, input, INSTR_WIDTH: instruction word.
REQ-010 Port s_last, input, 1: the current word is the final word of the program.
REQ-011 Port imem_we, output, 1: instruction-memory write strobe.
REQ-012 Port imem_addr, output, PC_WIDTH: write address.
REQ-013 Port imem_wdata, output, INSTR_WIDTH: write data.
REQ-014 Port core_rst, output, 1: active-high reset to the mips_16 core.
REQ-015 Port load_done, output, 1: program loaded and core running.
REQ-016 Port err, output, 1: overflow; the program exceeded memory capacity.
REQ-017 Port word_count, output, PC_WIDTH+1: words written in the current or last load.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, HOLD, RUN and ERR.
REQ-019 Transfer condition: s_valid && s_ready in the same cycle; s_ready SHALL be 1 only in LOAD.
REQ-020 IDLE: core_rst=1, s_ready=0; start -> LOAD, with the address counter and word_count cleared to 0.
REQ-021 LOAD: each transfer SHALL register imem_we=1, imem_addr=the current counter value and imem_wdata=s_data on the next cycle; counter and word_count increment by 1.
REQ-022 imem_we SHALL be a one-cycle pulse per transfer; back-to-back transfers give back-to-back pulses at consecutive addresses.
REQ-023 A transfer with s_last=1 SHALL move LOAD -> HOLD; the HOLD counter loads HOLD_CYCLES.
REQ-024 HOLD: core_rst=1; the counter decrements each cycle; at 0 -> RUN. The first core_rst=0 cycle SHALL be exactly HOLD_CYCLES+1 cycles after the last transfer edge.
REQ-025 RUN: core_rst=0 and load_done=1; start -> LOAD, with core_rst=1 and load_done=0 on the next cycle and the counters cleared.
REQ-026 Overflow: a transfer at address 2^PC_WIDTH-1 without s_last SHALL write that word, then enter ERR; word_count = 2^PC_WIDTH.
REQ-027 ERR: err=1, core_rst=1, s_ready=0; start -> LOAD, with err cleared and the counters cleared.
REQ-028 A transfer at the final address with s_last=1 SHALL be a legal full load -> HOLD, with err=0.
REQ-029 start in LOAD or HOLD SHALL be ignored.
REQ-030 start and a transfer in the same cycle cannot occur in IDLE, RUN or ERR, because s_ready=0 in those states.
REQ-031 s_data and s_last SHALL be sampled only on a transfer; s_valid without s_ready has no effect.
REQ-032 word_count SHALL hold its value through HOLD, RUN and ERR until the next start.

Reset
REQ-033 With rst=0 at a clock edge: state=IDLE, core_rst=1, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, err=0, word_count=0.
REQ-034 Reset in the middle of a load SHALL abort it; no imem_we pulse SHALL follow the reset edge, including for a transfer accepted in the cycle before.
REQ-035 core_rst SHALL stay 1 from reset until a completed HOLD.

Structure
REQ-036 The state encoding and the PC_WIDTH/INSTR_WIDTH defaults SHALL live in the shared mips_16 definitions package.
REQ-037 There SHALL be a single module with no sub-modules; the HOLD counter is inline.
REQ-038 The block SHALL connect to the write port of the IF-stage instruction ROM and to the core reset input, in place of bench-side memory preloading.

Verification
REQ-039 Reset, then start, then 3 words 0x1111/0x2222/0x3333 with last on the third -> writes at addresses 0,1,2; word_count=3; core_rst falls 5 cycles after the third transfer edge; load_done=1.
REQ-040 Same program with s_valid toggling every other cycle -> identical writes, no duplicates, no gaps in addresses.
REQ-041 PC_WIDTH=4, 16 words with no last -> 16 writes, err=1, core_rst=1, word_count=16; start then 1 word with last -> err=0, address 0 written, RUN.
REQ-042 PC_WIDTH=4, 16 words with last on the 16th -> HOLD then RUN, err=0.
REQ-043 rst=0 after the 2nd of 4 words -> no further imem_we, IDLE, core_rst=1; start reloads from address 0.
REQ-044 In RUN, start -> core_rst=1 and load_done=0 next cycle; start pulses during LOAD have no effect.

Source files
------------

// File: rtl/mips_16_pkg.sv
// rtl/mips_16_pkg.sv - shared mips_16 definitions: widths and program-loader state encoding
package mips_16_pkg;

    localparam int MIPS16_PC_WIDTH    = 8;
    localparam int MIPS16_INSTR_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HOLD = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } ldr_state_e;

endpackage

// File: rtl/mips_16_prog_loader.sv
// rtl/mips_16_prog_loader.sv - streams a program into the IF-stage instruction ROM and releases core reset
module mips_16_prog_loader
    import mips_16_pkg::*;
#(
    parameter int PC_WIDTH    = MIPS16_PC_WIDTH,
    parameter int INSTR_WIDTH = MIPS16_INSTR_WIDTH,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [INSTR_WIDTH-1:0] s_data,
    input  logic                   s_last,
    output logic                   imem_we,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   core_rst,
    output logic                   load_done,
    output logic                   err,
    output logic [PC_WIDTH:0]      word_count
);

    localparam int HCW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HCW-1:0]      HOLD_INIT = HCW'(HOLD_CYCLES);
    localparam logic [HCW-1:0]      HOLD_ONE  = HCW'(1);
    localparam logic [PC_WIDTH-1:0] ADDR_MAX  = '1;
    localparam logic [PC_WIDTH-1:0] ADDR_ONE  = PC_WIDTH'(1);
    localparam logic [PC_WIDTH:0]   WC_ONE    = (PC_WIDTH + 1)'(1);

    ldr_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic [PC_WIDTH:0]      wc_q, wc_d;
    logic [HCW-1:0]         hold_q, hold_d;
    logic                   we_q, we_d;
    logic [PC_WIDTH-1:0]    waddr_q, waddr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
    logic                   core_rst_q, load_done_q, err_q;
    logic                   xfer;

    assign s_ready = (state_q == LOAD);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wc_d    = wc_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    wc_d    = '0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = s_data;
                    addr_d  = addr_q + ADDR_ONE;
                    wc_d    = wc_q + WC_ONE;
                    // s_last on the final address is a legal full load, not an overflow
                    if (s_last) begin
                        state_d = HOLD;
                        hold_d  = HOLD_INIT;
                    end else if (addr_q == ADDR_MAX) begin
                        state_d = ERR;
                    end
                end
            end
            HOLD: begin
                if (hold_q == '0) state_d = RUN;
                else              hold_d  = hold_q - HOLD_ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // status outputs follow the next state so they change on the same edge as the FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wc_q        <= '0;
            hold_q      <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            core_rst_q  <= 1'b1;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wc_q        <= wc_d;
            hold_q      <= hold_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            core_rst_q  <= (state_d != RUN);
            load_done_q <= (state_d == RUN);
            err_q       <= (state_d == ERR);
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = waddr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;
    assign load_done  = load_done_q;
    assign err        = err_q;
    assign word_count = wc_q;

endmodule
